// File: rtl/modmul_pkg.sv
// Shared definitions for the modular-multiplier arbiter: FSM state
// encoding, mod_sel width and statistics counter width.
package modmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int MOD_SEL_W = 2;
  localparam int STAT_W    = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts one past last_grant and wraps.
// Purely combinational; returns a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IDXW = $clog2(NREQ);

  // Walk the requesters in rotating priority order and keep the first hit.
  always_comb begin
    int cand;
    any  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = IDXW'(cand);
      end
    end
  end

  // Expand the winning index into a one-hot grant vector.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign grant[gi] = any && (idx == IDXW'(gi));
  end

endmodule

// File: rtl/modmul_arbiter.sv
// Round-robin front end that shares one combinational modulo multiplier
// among NREQ requesters. IDLE grants one requester and latches its
// operands, EXEC lets the multiplier settle and captures its product,
// RESP holds the result until the consumer accepts it.
// Optional: define MODMUL_ARB_STATS_EN to add per-requester saturating
// grant counters on port grant_cnt.
module modmul_arbiter
  import modmul_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*N-1:0]         a_in,
  input  logic [NREQ*N-1:0]         b_in,
  input  logic [NREQ*MOD_SEL_W-1:0] mod_sel_in,
  output logic [NREQ-1:0]           ack,
  output logic [N-1:0]              mul_a,
  output logic [N-1:0]              mul_b,
  output logic [MOD_SEL_W-1:0]      mul_mod_sel,
  input  logic [2*N-1:0]            mul_p,
  output logic                      res_valid,
  output logic [2*N-1:0]            res_p,
  output logic [$clog2(NREQ)-1:0]   res_tag,
  input  logic                      res_ready,
  output logic                      busy
`ifdef MODMUL_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0]    grant_cnt
`endif
);

  localparam int IDXW = $clog2(NREQ);

  state_e                 state_reg, state_next;
  logic [N-1:0]           op_a_reg;
  logic [N-1:0]           op_b_reg;
  logic [MOD_SEL_W-1:0]   op_sel_reg;
  logic [IDXW-1:0]        op_idx_reg;
  logic [IDXW-1:0]        last_grant_reg;
  logic [NREQ-1:0]        ack_reg;
  logic [2*N-1:0]         res_p_reg;
  logic [IDXW-1:0]        res_tag_reg;

  logic [NREQ-1:0]        win_grant;
  logic [IDXW-1:0]        win_idx;
  logic                   win_any;
  logic                   grant_now;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (win_grant),
    .idx        (win_idx),
    .any        (win_any)
  );

  // A grant happens only from IDLE; req is ignored in every other state.
  assign grant_now = (state_reg == ST_IDLE) && win_any;

  // Next-state selection for the three-phase issue cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (win_any)   state_next = ST_EXEC;
      ST_EXEC:                state_next = ST_RESP;
      ST_RESP: if (res_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // State, operand capture, grant history, ack pulse and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_sel_reg     <= '0;
      op_idx_reg     <= '0;
      last_grant_reg <= IDXW'(NREQ - 1);
      ack_reg        <= '0;
      res_p_reg      <= '0;
      res_tag_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= '0;
      if (grant_now) begin
        op_a_reg       <= a_in[win_idx*N +: N];
        op_b_reg       <= b_in[win_idx*N +: N];
        op_sel_reg     <= mod_sel_in[win_idx*MOD_SEL_W +: MOD_SEL_W];
        op_idx_reg     <= win_idx;
        last_grant_reg <= win_idx;
        ack_reg        <= win_grant;
      end
      if (state_reg == ST_EXEC) begin
        res_p_reg   <= mul_p;
        res_tag_reg <= op_idx_reg;
      end
    end
  end

  // Multiplier operands always come straight from the operand registers,
  // so there is no combinational path from req to the multiplier.
  assign mul_a       = op_a_reg;
  assign mul_b       = op_b_reg;
  assign mul_mod_sel = op_sel_reg;

  assign ack       = ack_reg;
  assign res_valid = (state_reg == ST_RESP);
  assign res_p     = res_p_reg;
  assign res_tag   = res_tag_reg;
  assign busy      = (state_reg != ST_IDLE);

`ifdef MODMUL_ARB_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [STAT_W-1:0] cnt_reg;

    // Count acks to this requester, holding at all-ones once saturated.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (ack_reg[gi] && (cnt_reg != {STAT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign grant_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_modmul_arbiter.sv
// Self-checking bench for modmul_arbiter with a stub multiplier (A*B).
// Expected grants, results and counts come from a small reference model.
module tb_modmul_arbiter;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [7:0]  mod_sel_in = '0;
  logic [3:0]  ack;
  logic [7:0]  mul_a, mul_b;
  logic [1:0]  mul_mod_sel;
  logic [15:0] mul_p;
  logic        res_valid;
  logic [15:0] res_p;
  logic [1:0]  res_tag;
  logic        res_ready = 1'b0;
  logic        busy;
`ifdef MODMUL_ARB_STATS_EN
  logic [63:0] grant_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_ack_cyc = 0;

  // reference model state
  int ma [NREQ];
  int mb [NREQ];
  int last_g;
  int gcnt [NREQ];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stub modulo multiplier: plain signed product
  assign mul_p = 16'(16'($signed(mul_a)) * 16'($signed(mul_b)));

  modmul_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .a_in        (a_in),
    .b_in        (b_in),
    .mod_sel_in  (mod_sel_in),
    .ack         (ack),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_mod_sel (mul_mod_sel),
    .mul_p       (mul_p),
    .res_valid   (res_valid),
    .res_p       (res_p),
    .res_tag     (res_tag),
    .res_ready   (res_ready),
    .busy        (busy)
`ifdef MODMUL_ARB_STATS_EN
    ,
    .grant_cnt   (grant_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // round-robin choice: first requester after the previous winner
  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last_g + k) % NREQ;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*8 +: 8] = 8'(ma[i]);
      b_in[i*8 +: 8] = 8'(mb[i]);
    end
  endtask

  task automatic new_ops();
    for (int i = 0; i < NREQ; i++) begin
      ma[i] = int'($urandom_range(0, 255)) - 128;
      mb[i] = int'($urandom_range(0, 255)) - 128;
      mod_sel_in[i*2 +: 2] = 2'($urandom_range(0, 3));
    end
    pack_ops();
  endtask

  // One full grant/execute/response transaction, checked cycle by cycle.
  task automatic run_txn(input logic [3:0] r, input int stall, input bit drop, input bit gap);
    int w;
    logic [15:0] ep;
    req       = r;
    res_ready = (stall == 0);
    w = pick(r);
    @(posedge clk); #1;
    chk("ack_grant", {28'd0, ack}, 32'(1 << w));
    chk("busy_exec", {31'd0, busy}, 32'd1);
    chk("mul_a", {24'd0, mul_a}, {24'd0, 8'(ma[w])});
    chk("mul_sel", {30'd0, mul_mod_sel}, {30'd0, mod_sel_in[w*2 +: 2]});
    if (gap) chk("ack_gap", 32'(cyc - last_ack_cyc), 32'd3);
    last_ack_cyc = cyc;
    last_g = w;
    gcnt[w]++;
    if (drop) req[w] = 1'b0;
    ep = 16'(ma[w] * mb[w]);
    @(posedge clk); #1;
    chk("ack_drop", {28'd0, ack}, 32'd0);
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_p", {16'd0, res_p}, {16'd0, ep});
    chk("res_tag", {30'd0, res_tag}, 32'(w));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, res_valid}, 32'd1);
      chk("stall_p", {16'd0, res_p}, {16'd0, ep});
      chk("stall_tag", {30'd0, res_tag}, 32'(w));
      chk("stall_ack", {28'd0, ack}, 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_valid", {31'd0, res_valid}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_ack", {28'd0, ack}, 32'd0);
  endtask

  initial begin
    last_g = NREQ - 1;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    new_ops();

    // reset held with every requester asking
    rst = 1'b0; req = 4'hF; res_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_ack", {28'd0, ack}, 32'd0);
      chk("rst_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_p", {16'd0, res_p}, 32'd0);
      chk("rst_tag", {30'd0, res_tag}, 32'd0);
      chk("rst_mula", {24'd0, mul_a}, 32'd0);
    end
    rst = 1'b1;

    // all requesters held: rotation 0,1,2,3,0 with acks 3 cycles apart
    for (int i = 0; i < 5; i++) run_txn(4'hF, 0, 1'b0, i != 0);

    // single requester 2, 3 * -5
    ma[2] = 3; mb[2] = -5; pack_ops();
    run_txn(4'b0100, 0, 1'b1, 1'b0);
    chk("neg_prod", {16'd0, res_p}, 32'h0000_FFF1);

    // consumer stalls for 5 cycles
    new_ops();
    run_txn(4'($urandom_range(1, 15)), 5, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 20; i++) begin
      new_ops();
      run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 2)), 1'b1, 1'b0);
    end

    // reset during EXEC discards the operation
    new_ops();
    req = 4'b1000;
    @(posedge clk); #1;
    chk("pre_rst_ack", {28'd0, ack}, 32'(1 << pick(4'b1000)));
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_ack", {28'd0, ack}, 32'd0);
    req = 4'b0000;
    last_g = NREQ - 1;
    for (int i = 0; i < NREQ; i++) gcnt[i] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", {31'd0, res_valid}, 32'd0);
      chk("post_rst_ack", {28'd0, ack}, 32'd0);
    end
    run_txn(4'hF, 0, 1'b1, 1'b0);
    chk("post_rst_tag", {30'd0, res_tag}, 32'd0);

`ifdef MODMUL_ARB_STATS_EN
    for (int i = 0; i < 3; i++) run_txn(4'b0010, 0, 1'b1, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++)
      chk("grant_cnt", {16'd0, grant_cnt[i*16 +: 16]}, 32'(gcnt[i]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
